// File: rtl/lbp_engine.sv
// 3x3 local-binary-pattern engine: streams a frame from a 1-cycle-latency gray
// memory through a sliding window and writes one code per pixel.
module lbp_engine #(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int DW          = 8,
  parameter int AW          = 14,
  parameter int BORDER_FILL = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  input  logic          mode,
  input  logic [DW-1:0] thr,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  typedef enum logic [2:0] {IDLE, ROW_LOAD, SLIDE, DRAIN, BORDER, DONE} state_t;

  localparam logic [AW-1:0] W_L = AW'(IMG_W);
  localparam logic [AW-1:0] H_L = AW'(IMG_H);
  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW-1:0] TWO = AW'(2);

  state_t state, next_state;

  logic [AW-1:0] x, y, bx, by;
  logic [3:0]    rd_cnt;
  logic [1:0]    rd_row, rd_col;
  logic [AW-1:0] rd_addr;
  logic          issue, last_rd, x_end, y_end, border_last;

  logic          pend, pend_shift, pend_last;
  logic [1:0]    pend_row, pend_col;
  logic [AW-1:0] pend_center, done_center;
  logic          win_done, border_done;
  logic          mode_q;
  logic [DW-1:0] thr_q;
  logic [DW-1:0] win [3][3];

  logic [DW-1:0] nb [8];
  logic [DW:0]   ref_val;
  logic [7:0]    code;

  assign issue       = (state == ROW_LOAD || state == SLIDE) && gray_ready;
  assign last_rd     = (state == ROW_LOAD && rd_cnt == 4'd8) || (state == SLIDE && rd_cnt == 4'd2);
  assign x_end       = (x == W_L - TWO);
  assign y_end       = (y == H_L - TWO);
  assign border_last = (bx == W_L - ONE) && (by == H_L - ONE);

  // ROW_LOAD fetches column-major (left column first); SLIDE fetches only the new right column.
  always_comb begin
    rd_row = 2'd0;
    rd_col = 2'd2;
    if (state == SLIDE) begin
      rd_row = rd_cnt[1:0];
    end else begin
      rd_row = 2'(rd_cnt % 4'd3);
      rd_col = 2'(rd_cnt / 4'd3);
    end
    rd_addr = (y + AW'(rd_row) - ONE) * W_L + (x + AW'(rd_col) - ONE);
  end

  // Threshold sum is one bit wider so a saturating centre never wraps to a small value.
  always_comb begin
    ref_val = {1'b0, win[1][1]} + (mode_q ? {1'b0, thr_q} : '0);
    nb[0] = win[0][0];
    nb[1] = win[0][1];
    nb[2] = win[0][2];
    nb[3] = win[1][0];
    nb[4] = win[1][2];
    nb[5] = win[2][0];
    nb[6] = win[2][1];
    nb[7] = win[2][2];
    code = '0;
    for (int i = 0; i < 8; i++) code[i] = ({1'b0, nb[i]} >= ref_val);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // DRAIN waits until the final write strobe is on the bus, so finish follows it by one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (gray_ready && !finish) next_state = ROW_LOAD;
      ROW_LOAD,
      SLIDE:    if (issue && last_rd) next_state = !x_end ? SLIDE : (!y_end ? ROW_LOAD : DRAIN);
      DRAIN:    if (lbp_valid && !win_done && !pend)
                  next_state = (BORDER_FILL != 0 && !border_done) ? BORDER : DONE;
      BORDER:   if (border_last) next_state = DRAIN;
      DONE:     next_state = DONE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gray_req    <= 1'b0;
      gray_addr   <= '0;
      lbp_valid   <= 1'b0;
      lbp_addr    <= '0;
      lbp_data    <= '0;
      finish      <= 1'b0;
      x           <= '0;
      y           <= '0;
      bx          <= '0;
      by          <= '0;
      rd_cnt      <= '0;
      pend        <= 1'b0;
      pend_shift  <= 1'b0;
      pend_last   <= 1'b0;
      pend_row    <= '0;
      pend_col    <= '0;
      pend_center <= '0;
      done_center <= '0;
      win_done    <= 1'b0;
      border_done <= 1'b0;
      mode_q      <= 1'b0;
      thr_q       <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else begin
      gray_req    <= issue;
      pend        <= issue;
      pend_row    <= rd_row;
      pend_col    <= rd_col;
      pend_shift  <= (state == SLIDE) && (rd_cnt == 4'd0);
      pend_last   <= last_rd;
      pend_center <= y * W_L + x;
      lbp_valid   <= 1'b0;
      finish      <= (next_state == DONE);

      if (state == IDLE && gray_ready && !finish) begin
        x      <= ONE;
        y      <= ONE;
        rd_cnt <= '0;
        mode_q <= mode;
        thr_q  <= thr;
      end

      if (issue) begin
        gray_addr <= rd_addr;
        if (last_rd) begin
          rd_cnt <= '0;
          if (!x_end) begin
            x <= x + ONE;
          end else begin
            x <= ONE;
            if (!y_end) y <= y + ONE;
          end
        end else begin
          rd_cnt <= rd_cnt + 4'd1;
        end
      end

      // The first fetch of a new column shifts the whole window left before landing top-right.
      if (pend) begin
        if (pend_shift) begin
          for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
          end
          win[0][2] <= gray_data;
        end else begin
          win[pend_row][pend_col] <= gray_data;
        end
      end

      win_done <= pend && pend_last;
      if (pend && pend_last) done_center <= pend_center;

      if (win_done) begin
        lbp_valid <= 1'b1;
        lbp_addr  <= done_center;
        lbp_data  <= code;
      end

      if (state == BORDER) begin
        lbp_valid <= 1'b1;
        lbp_addr  <= by * W_L + bx;
        lbp_data  <= 8'h00;
        if (border_last) border_done <= 1'b1;
        if (by == '0 || by == H_L - ONE) begin
          if (bx == W_L - ONE) begin
            bx <= '0;
            by <= by + ONE;
          end else begin
            bx <= bx + ONE;
          end
        end else if (bx == '0) begin
          bx <= W_L - ONE;
        end else begin
          bx <= '0;
          by <= by + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_lbp_engine.sv
// Scoreboard bench: a 4x4 border-filling engine and a 7x5 interior-only engine
// share control inputs; expected writes are queued per frame and popped per strobe.
module tb_lbp_engine;

  localparam int WA = 4, HA = 4, AWA = 4;
  localparam int WB = 7, HB = 5, AWB = 6;
  localparam int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  localparam int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  typedef logic [7:0] frame_t [64];
  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, gray_ready, mode;
  logic [7:0] thr;

  logic           gray_req_a, lbp_valid_a, finish_a;
  logic [AWA-1:0] gray_addr_a, lbp_addr_a;
  logic [7:0]     gray_data_a, lbp_data_a;
  logic           gray_req_b, lbp_valid_b, finish_b;
  logic [AWB-1:0] gray_addr_b, lbp_addr_b;
  logic [7:0]     gray_data_b, lbp_data_b;

  frame_t img_a, img_b;
  wr_t    q_a[$], q_b[$];
  int     checks_total = 0, checks_passed = 0;
  int     wr_a, wr_b, rd_b;

  lbp_engine #(.IMG_W(WA), .IMG_H(HA), .DW(8), .AW(AWA), .BORDER_FILL(1)) dut_a (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req_a),
    .gray_addr(gray_addr_a), .gray_data(gray_data_a), .mode(mode), .thr(thr),
    .lbp_valid(lbp_valid_a), .lbp_addr(lbp_addr_a), .lbp_data(lbp_data_a), .finish(finish_a));

  lbp_engine #(.IMG_W(WB), .IMG_H(HB), .DW(8), .AW(AWB), .BORDER_FILL(0)) dut_b (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req_b),
    .gray_addr(gray_addr_b), .gray_data(gray_data_b), .mode(mode), .thr(thr),
    .lbp_valid(lbp_valid_b), .lbp_addr(lbp_addr_b), .lbp_data(lbp_data_b), .finish(finish_b));

  // Gray memories answer mid-cycle; without a request they return noise.
  always @(negedge clk) begin
    gray_data_a <= gray_req_a ? img_a[gray_addr_a] : 8'($urandom);
    gray_data_b <= gray_req_b ? img_b[gray_addr_b] : 8'($urandom);
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_code(input frame_t f, input int w, input int x, input int y,
                                          input bit m, input int t);
    int lim;
    logic [7:0] c;
    lim = int'(f[y*w + x]) + (m ? t : 0);
    c = 8'h00;
    for (int i = 0; i < 8; i++)
      if (int'(f[(y + DY[i])*w + x + DX[i]]) >= lim) c[i] = 1'b1;
    return c;
  endfunction

  task automatic push_frame();
    q_a.delete();
    q_b.delete();
    for (int y = 1; y < HA - 1; y++)
      for (int x = 1; x < WA - 1; x++)
        q_a.push_back('{addr: 8'(y*WA + x), data: ref_code(img_a, WA, x, y, mode, int'(thr))});
    for (int a = 0; a < WA*HA; a++)
      if (a % WA == 0 || a % WA == WA - 1 || a / WA == 0 || a / WA == HA - 1)
        q_a.push_back('{addr: 8'(a), data: 8'h00});
    for (int y = 1; y < HB - 1; y++)
      for (int x = 1; x < WB - 1; x++)
        q_b.push_back('{addr: 8'(y*WB + x), data: ref_code(img_b, WB, x, y, mode, int'(thr))});
    wr_a = 0;
    wr_b = 0;
    rd_b = 0;
  endtask

  task automatic check_reset();
    check_output("a_reset_outs", 32'({gray_req_a, gray_addr_a, lbp_valid_a, lbp_addr_a, lbp_data_a, finish_a}), 32'd0);
    check_output("b_reset_outs", 32'({gray_req_b, gray_addr_b, lbp_valid_b, lbp_addr_b, lbp_data_b, finish_b}), 32'd0);
  endtask

  // Called once per negedge while a frame is in flight.
  task automatic sample_cycle();
    wr_t e;
    if (gray_req_b) rd_b++;
    if (lbp_valid_a) begin
      wr_a++;
      if (q_a.size() == 0) check_output("a_write_count", wr_a, WA*HA);
      else begin
        e = q_a.pop_front();
        check_output("a_addr", 32'(lbp_addr_a), 32'(e.addr));
        check_output("a_data", 32'(lbp_data_a), 32'(e.data));
      end
    end
    if (lbp_valid_b) begin
      wr_b++;
      if (q_b.size() == 0) check_output("b_write_count", wr_b, (WB-2)*(HB-2));
      else begin
        e = q_b.pop_front();
        check_output("b_addr", 32'(lbp_addr_b), 32'(e.addr));
        check_output("b_data", 32'(lbp_data_b), 32'(e.data));
      end
    end
  endtask

  task automatic stall(input int n);
    gray_ready = 1'b0;
    repeat (n) begin
      @(negedge clk);
      sample_cycle();
      check_output("a_req_stall", 32'(gray_req_a), 32'd0);
      check_output("b_req_stall", 32'(gray_req_b), 32'd0);
    end
    gray_ready = 1'b1;
  endtask

  // pattern: 0 = ramp (index), 1 = flat 100, 2 = flat 255, 3 = random
  task automatic apply_stimulus(input bit m, input logic [7:0] t, input int pattern,
                                input bit do_stall, input int abort_at, input bit scramble);
    bit s1 = 0, s2 = 0, aborted = 0;
    reset = 1'b0;
    gray_ready = 1'b1;
    mode = m;
    thr = t;
    for (int i = 0; i < 64; i++) begin
      case (pattern)
        0: begin img_a[i] = 8'(i); img_b[i] = 8'(i); end
        1: begin img_a[i] = 8'd100; img_b[i] = 8'd100; end
        2: begin img_a[i] = 8'd255; img_b[i] = 8'd255; end
        default: begin img_a[i] = 8'($urandom); img_b[i] = 8'($urandom); end
      endcase
    end
    push_frame();
    repeat (2) @(negedge clk);
    check_reset();
    reset = 1'b1;
    for (int c = 0; c < 3000 && !(finish_a && finish_b); c++) begin
      @(negedge clk);
      sample_cycle();
      if (scramble && c == 3) begin
        mode = ~m;
        thr = ~t;
      end
      if (do_stall && !s1 && rd_b == 10) begin s1 = 1; stall(5); end
      if (do_stall && !s2 && rd_b == 24) begin s2 = 1; stall(3); end
      if (abort_at > 0 && !aborted && wr_b == abort_at) begin
        aborted = 1;
        reset = 1'b0;
        @(negedge clk);
        check_reset();
        push_frame();
        reset = 1'b1;
      end
    end
    check_output("a_finish", 32'(finish_a), 32'd1);
    check_output("b_finish", 32'(finish_b), 32'd1);
    repeat (3) begin
      @(negedge clk);
      sample_cycle();
    end
    check_output("a_finish_sticky", 32'(finish_a), 32'd1);
    check_output("b_finish_sticky", 32'(finish_b), 32'd1);
    check_output("a_writes", wr_a, WA*HA);
    check_output("b_writes", wr_b, (WB-2)*(HB-2));
    check_output("a_queue_left", q_a.size(), 0);
    check_output("b_queue_left", q_b.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    gray_ready = 1'b0;
    mode = 1'b0;
    thr = 8'h00;
    repeat (3) @(negedge clk);
    check_reset();

    $display("[TB] ramp frame, mode 0");
    apply_stimulus(1'b0, 8'd0, 0, 1'b0, 0, 1'b0);
    $display("[TB] flat 100 frames");
    apply_stimulus(1'b0, 8'd0, 1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 8'd1, 1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 8'd0, 1, 1'b0, 0, 1'b0);
    $display("[TB] saturated frames");
    apply_stimulus(1'b1, 8'd1, 2, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 8'd0, 2, 1'b0, 0, 1'b0);
    $display("[TB] random frames: stall, mid-frame reset, late mode change");
    apply_stimulus(1'b0, 8'd0, 3, 1'b1, 0, 1'b0);
    apply_stimulus(1'b1, 8'd20, 3, 1'b0, 6, 1'b0);
    apply_stimulus(1'b1, 8'd5, 3, 1'b0, 0, 1'b1);
    apply_stimulus(1'b0, 8'd0, 3, 1'b1, 0, 1'b1);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
